fpu_round_arbiter: RTL and testbench

//  Shares one 2-stage pipelined rounding datapath between two requesters, A (adder) and B (multiplier).

---
 rtl/fpu_round_arbiter.sv | 131 +++++++++++++
 tb/tb_fpu_round_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_round_arbiter.sv
// fpu_round_arbiter: round-robin share of a 2-stage IEEE 754 rounding pipeline between an adder (A) and a multiplier (B)
// Stage 1 registers the granted request and its increment decision, stage 2 registers the rounded result.
module fpu_round_arbiter #(
    parameter int EXPONENT_WIDTH    = 11,
    parameter int SIGNIFICAND_WIDTH = 52
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic                         a_sign,
    input  logic [EXPONENT_WIDTH-1:0]    a_exponent,
    input  logic [SIGNIFICAND_WIDTH:0]   a_signif,
    input  logic [2:0]                   a_grs,
    input  logic [2:0]                   a_mode,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic                         b_sign,
    input  logic [EXPONENT_WIDTH-1:0]    b_exponent,
    input  logic [SIGNIFICAND_WIDTH:0]   b_signif,
    input  logic [2:0]                   b_grs,
    input  logic [2:0]                   b_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_tag,
    output logic                         out_sign,
    output logic [EXPONENT_WIDTH-1:0]    out_exponent,
    output logic [SIGNIFICAND_WIDTH:0]   out_signif,
    output logic                         out_inexact,
    output logic                         out_overflow
);
    localparam int EW = EXPONENT_WIDTH;
    localparam int SW = SIGNIFICAND_WIDTH;

    logic          rr;
    logic          a_win, b_win, s1_adv, s2_adv, accept;
    logic          sel_sign, sel_special, sel_any, sel_inc, sel_to_inf;
    logic [EW-1:0] sel_exp;
    logic [SW:0]   sel_signif;
    logic [2:0]    sel_grs, sel_mode, md;

    logic          s1_valid, s1_tag, s1_sign, s1_inc, s1_inexact, s1_to_inf;
    logic [EW-1:0] s1_exp;
    logic [SW:0]   s1_signif;

    logic [SW+1:0] sum;
    logic          carry, ovf;
    logic [EW-1:0] new_exp, round_exp;
    logic [SW:0]   round_signif;

    always_comb begin
        a_win       = a_valid & (~b_valid | ~rr);
        b_win       = b_valid & ~a_win;
        s1_adv      = ~s1_valid | ~out_valid | out_ready;
        s2_adv      = ~out_valid | out_ready;
        a_ready     = ~rst & s1_adv & a_win;
        b_ready     = ~rst & s1_adv & b_win;
        accept      = a_ready | b_ready;
        sel_sign    = b_win ? b_sign : a_sign;
        sel_exp     = b_win ? b_exponent : a_exponent;
        sel_signif  = b_win ? b_signif : a_signif;
        sel_grs     = b_win ? b_grs : a_grs;
        sel_mode    = b_win ? b_mode : a_mode;
        md          = sel_mode > 3'd4 ? 3'd0 : sel_mode;
        sel_special = &sel_exp;
        sel_any     = |sel_grs;
        // Inf/NaN operands pass through untouched, so they never round or flag
        sel_inc     = sel_special ? 1'b0 :
                      md == 3'd0  ? sel_grs[2] & (sel_grs[1] | sel_grs[0] | sel_signif[0]) :
                      md == 3'd1  ? sel_grs[2] :
                      md == 3'd2  ? ~sel_sign & sel_any :
                      md == 3'd3  ? sel_sign & sel_any : 1'b0;
        sel_to_inf  = md <= 3'd1 | (md == 3'd2 & ~sel_sign) | (md == 3'd3 & sel_sign);
    end

    always_comb begin
        sum          = {1'b0, s1_signif} + (SW+2)'(s1_inc);
        carry        = sum[SW+1];
        new_exp      = s1_exp + EW'(carry);
        ovf          = carry & (&new_exp);
        round_exp    = ovf ? (s1_to_inf ? {EW{1'b1}} : {{(EW-1){1'b1}}, 1'b0}) : new_exp;
        round_signif = ovf ? (s1_to_inf ? {(SW+1){1'b0}} : {(SW+1){1'b1}}) :
                       carry ? {1'b1, {SW{1'b0}}} : sum[SW:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr           <= 1'b0;
            s1_valid     <= 1'b0;
            s1_tag       <= 1'b0;
            s1_sign      <= 1'b0;
            s1_exp       <= '0;
            s1_signif    <= '0;
            s1_inc       <= 1'b0;
            s1_inexact   <= 1'b0;
            s1_to_inf    <= 1'b0;
            out_valid    <= 1'b0;
            out_tag      <= 1'b0;
            out_sign     <= 1'b0;
            out_exponent <= '0;
            out_signif   <= '0;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= accept;
                if (accept) begin
                    rr         <= a_win;
                    s1_tag     <= b_win;
                    s1_sign    <= sel_sign;
                    s1_exp     <= sel_exp;
                    s1_signif  <= sel_signif;
                    s1_inc     <= sel_inc;
                    s1_inexact <= sel_any & ~sel_special;
                    s1_to_inf  <= sel_to_inf;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_tag      <= s1_tag;
                    out_sign     <= s1_sign;
                    out_exponent <= round_exp;
                    out_signif   <= round_signif;
                    out_inexact  <= s1_inexact;
                    out_overflow <= ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_fpu_round_arbiter.sv
// tb_fpu_round_arbiter: directed and randomised checks of fpu_round_arbiter against a queue-based rounding model
module tb_fpu_round_arbiter;
    localparam int EW = 8;
    localparam int SW = 23;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [23:0] m;
        logic        inx;
        logic        ovf;
        logic        tag;
    } res_t;

    logic clk = 0, rst = 1;
    logic a_valid = 0, a_ready, a_sign = 0, b_valid = 0, b_ready, b_sign = 0;
    logic [7:0] a_exponent = 0, b_exponent = 0, out_exponent;
    logic [23:0] a_signif = 0, b_signif = 0, out_signif;
    logic [2:0] a_grs = 0, b_grs = 0, a_mode = 0, b_mode = 0;
    logic out_valid, out_ready = 1, out_tag, out_sign, out_inexact, out_overflow;

    int checks = 0, passes = 0;

    always #5 clk = ~clk;

    fpu_round_arbiter #(.EXPONENT_WIDTH(EW), .SIGNIFICAND_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_sign(a_sign), .a_exponent(a_exponent),
        .a_signif(a_signif), .a_grs(a_grs), .a_mode(a_mode),
        .b_valid(b_valid), .b_ready(b_ready), .b_sign(b_sign), .b_exponent(b_exponent),
        .b_signif(b_signif), .b_grs(b_grs), .b_mode(b_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_sign(out_sign),
        .out_exponent(out_exponent), .out_signif(out_signif),
        .out_inexact(out_inexact), .out_overflow(out_overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Rounding expressed as "how far past the half-way point is the discarded tail"
    function automatic res_t model_round(input logic tag, input logic s, input logic [7:0] e,
                                         input logic [23:0] m, input logic [2:0] g, input logic [2:0] md);
        res_t r;
        int v, ex, mm;
        logic up;
        mm = md > 3'd4 ? 0 : int'(md);
        r = '{s: s, e: e, m: m, inx: 1'b0, ovf: 1'b0, tag: tag};
        if (e == 8'hFF) return r;
        r.inx = g != 3'd0;
        case (mm)
            0: up = g > 3'd4 || (g == 3'd4 && m[0]);
            1: up = g >= 3'd4;
            2: up = !s && g != 3'd0;
            3: up = s && g != 3'd0;
            default: up = 1'b0;
        endcase
        v = int'(m) + int'(up);
        ex = int'(e);
        if (v == (1 << 24)) begin
            v = 1 << 23;
            ex++;
        end
        if (ex == 255) begin
            r.ovf = 1'b1;
            if (mm <= 1 || (mm == 2 && !s) || (mm == 3 && s)) begin
                r.e = 8'hFF;
                r.m = 24'h0;
            end else begin
                r.e = 8'hFE;
                r.m = 24'hFFFFFF;
            end
        end else begin
            r.e = 8'(ex);
            r.m = 24'(v);
        end
        return r;
    endfunction

    function automatic res_t cur_out();
        return res_t'({out_sign, out_exponent, out_signif, out_inexact, out_overflow, out_tag});
    endfunction

    res_t q[$];
    res_t prev_out, cur, expv;
    logic ptr = 0, pv = 0, pr = 0, win_b;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            ptr = 0;
            pv = 0;
            check("rst_out_valid", out_valid, 0);
            check("rst_ready", {a_ready, b_ready}, 0);
        end else begin
            cur = cur_out();
            if (pv && !pr) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", cur, prev_out);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("spurious_out", cur, 0);
                else begin
                    expv = q.pop_front();
                    check("out", cur, expv);
                end
            end
            check("one_ready", a_ready & b_ready, 0);
            if (a_valid || b_valid) begin
                win_b = !(a_valid && (!b_valid || !ptr));
                if (win_b) check("loser_a_ready", a_ready, 0);
                else check("loser_b_ready", b_ready, 0);
                if (win_b ? b_ready : a_ready) begin
                    q.push_back(win_b ? model_round(1, b_sign, b_exponent, b_signif, b_grs, b_mode)
                                      : model_round(0, a_sign, a_exponent, a_signif, a_grs, a_mode));
                    ptr = !win_b;
                end
            end
            pv = out_valid;
            pr = out_ready;
            prev_out = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic side, input logic s, input logic [7:0] e, input logic [23:0] m,
                       input logic [2:0] g, input logic [2:0] md);
        int n = 0;
        logic got = 0;
        if (side) begin
            {b_sign, b_exponent, b_signif, b_grs, b_mode} = {s, e, m, g, md};
            b_valid = 1;
        end else begin
            {a_sign, a_exponent, a_signif, a_grs, a_mode} = {s, e, m, g, md};
            a_valid = 1;
        end
        while (!got && n < 20) begin
            @(negedge clk);
            got = side ? b_ready : a_ready;
            tick();
            n++;
        end
        a_valid = 0;
        b_valid = 0;
        if (!got) check("req_timeout", 0, 1);
    endtask

    task automatic wait_out(output res_t r, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 10);
        if (!out_valid) check("out_timeout", 0, 1);
        r = cur_out();
        tick();
    endtask

    res_t r;
    int lat, acc;

    initial begin
        a_valid = 1;
        b_valid = 1;
        repeat (2) @(negedge clk);
        check("reset_data", {out_tag, out_sign, out_exponent, out_signif, out_inexact, out_overflow}, 0);
        a_valid = 0;
        b_valid = 0;
        tick();
        rst = 0;

        req(0, 0, 8'h80, 24'h800001, 3'b100, 0);
        wait_out(r, lat);
        check("t1_latency", lat, 2);
        check("t1_result", {r.m, r.e, r.tag, r.inx, r.ovf}, {24'h800002, 8'h80, 3'b010});
        req(0, 0, 8'h80, 24'h800000, 3'b100, 0);
        wait_out(r, lat);
        check("t1_tie_even", {r.m, r.e, r.inx}, {24'h800000, 8'h80, 1'b1});
        req(0, 0, 8'h80, 24'hFFFFFF, 3'b110, 0);
        wait_out(r, lat);
        check("t2_carry", {r.m, r.e, r.ovf}, {24'h800000, 8'h81, 1'b0});
        req(0, 0, 8'hFE, 24'hFFFFFF, 3'b100, 2);
        wait_out(r, lat);
        check("t3_rtp_ovf", {r.m, r.e, r.ovf, r.inx}, {24'h0, 8'hFF, 2'b11});
        req(0, 0, 8'hFE, 24'hFFFFFF, 3'b100, 3);
        wait_out(r, lat);
        check("t3_rtn", {r.m, r.e, r.inx, r.ovf}, {24'hFFFFFF, 8'hFE, 2'b10});
        req(1, 0, 8'h40, 24'h800003, 3'b100, 7);
        wait_out(r, lat);
        check("mode7_rne", {r.m, r.tag}, {24'h800004, 1'b1});
        req(0, 1, 8'hFF, 24'hC00001, 3'b111, 2);
        wait_out(r, lat);
        check("nan_pass", {r.s, r.m, r.e, r.inx, r.ovf}, {1'b1, 24'hC00001, 8'hFF, 2'b00});
        req(1, 1, 8'h10, 24'h800005, 3'b111, 4);
        wait_out(r, lat);
        check("rtz_neg", {r.m, r.inx, r.tag}, {24'h800005, 2'b11});

        // continuous requests against a stalled output
        out_ready = 0;
        acc = 0;
        a_exponent = 8'h20;
        b_exponent = 8'h30;
        a_grs = 3'b101;
        b_grs = 3'b011;
        for (int k = 0; k < 6; k++) begin
            a_signif = 24'hC00000 + 24'(k);
            b_signif = 24'hD00000 + 24'(k);
            a_valid = 1;
            b_valid = 1;
            @(negedge clk);
            if (a_ready || b_ready) acc++;
            tick();
        end
        @(negedge clk);
        check("bp_accepted", acc, 2);
        check("bp_readys", {a_ready, b_ready}, 0);
        tick();
        a_valid = 0;
        b_valid = 0;
        out_ready = 1;
        repeat (4) tick();
        check("bp_drained", q.size(), 0);

        // reset with both stages full, then fairness from a fresh pointer
        out_ready = 0;
        a_valid = 1;
        b_valid = 1;
        repeat (4) tick();
        rst = 1;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_ready", {a_ready, b_ready}, 0);
        tick();
        tick();
        rst = 0;
        out_ready = 1;
        a_grs = 0;
        b_grs = 0;
        a_mode = 0;
        b_mode = 0;
        for (int k = 0; k < 10; k++) begin
            a_signif = 24'hA00000 + 24'(k);
            b_signif = 24'hB00000 + 24'(k);
            @(negedge clk);
            if (k >= 2) begin
                check("fair_valid", out_valid, 1);
                check("fair_tag", out_tag, (k - 2) % 2);
            end
            if (k == 2) check("post_rst_first", out_signif, 24'hA00000);
            tick();
        end
        a_valid = 0;
        b_valid = 0;
        repeat (4) tick();

        for (int k = 0; k < 300; k++) begin
            a_valid = $urandom_range(0, 1);
            b_valid = $urandom_range(0, 1);
            out_ready = $urandom_range(0, 3) != 0;
            a_sign = $urandom_range(0, 1);
            b_sign = $urandom_range(0, 1);
            a_exponent = $urandom_range(0, 3) == 0 ? 8'hFE : ($urandom_range(0, 7) == 0 ? 8'hFF : 8'($urandom));
            b_exponent = $urandom_range(0, 3) == 0 ? 8'hFE : 8'($urandom);
            a_signif = $urandom_range(0, 2) == 0 ? 24'hFFFFFF : (24'($urandom) | 24'h800000);
            b_signif = $urandom_range(0, 2) == 0 ? 24'hFFFFFF : (24'($urandom) | 24'h800000);
            a_grs = 3'($urandom);
            b_grs = 3'($urandom);
            a_mode = 3'($urandom);
            b_mode = 3'($urandom);
            tick();
        end
        a_valid = 0;
        b_valid = 0;
        out_ready = 1;
        repeat (5) tick();
        check("final_drained", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
